// File: rtl/clb_cfg_pkg.sv
// clb_cfg_pkg: shared states, defaults and field offsets for the clb1 configuration loader
package clb_cfg_pkg;

    typedef enum logic [2:0] {IDLE, SYNC, LOAD, PARITY, COMMIT} state_e;

    localparam int DEF_CFG_W = 34;
    localparam int DEF_PRE_W = 8;
    localparam logic [7:0] DEF_PREAMBLE = 8'hA5;
    localparam int DEF_SYNC_MAX = 64;

    localparam int X_LUT_LSB = 0;
    localparam int Y_LUT_LSB = 16;
    localparam int MODE_LSB = 32;

endpackage

// File: rtl/clb_cfg_shreg.sv
// clb_cfg_shreg: left-shifting register with enable, synchronous clear and parity of its contents
module clb_cfg_shreg #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         d_i,
    output logic [W-1:0] q_o,
    output logic         par_o
);

    logic [W-1:0] q_q, q_d;

    // clear wins over shift; new bits enter at the LSB
    always_comb begin
        q_d = clr_i ? '0 : en_i ? {q_q[W-2:0], d_i} : q_q;
    end

    // register with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q_o   = q_q;
    assign par_o = ^q_q;

endmodule

// File: rtl/clb_cfg_loader.sv
// clb_cfg_loader: framed serial bitstream loader committing LUT masks and mode bits to a clb1
module clb_cfg_loader
    import clb_cfg_pkg::*;
#(
    parameter int               CFG_W    = DEF_CFG_W,
    parameter int               PRE_W    = DEF_PRE_W,
    parameter logic [PRE_W-1:0] PREAMBLE = DEF_PREAMBLE,
    parameter int               SYNC_MAX = DEF_SYNC_MAX
) (
    input  logic             K,
    input  logic             RST,
    input  logic             START,
    input  logic             DIN,
    input  logic             DIN_VLD,
    output logic             DIN_RDY,
    output logic [CFG_W-1:0] CFG,
    output logic             CFG_WE,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR
);

    localparam int BCW = $clog2(CFG_W + 1);
    localparam int SCW = $clog2(SYNC_MAX + 1);

    state_e           state_q, state_d;
    logic [BCW-1:0]   bit_cnt_q, bit_cnt_d;
    logic [SCW-1:0]   sync_cnt_q, sync_cnt_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic             cfg_we_q, cfg_we_d;
    logic             din_rdy_q, din_rdy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             xfer, clr, win_en, sh_en;
    logic [PRE_W-1:0] win_q, win_nxt;
    logic [CFG_W-1:0] shadow_q;
    logic             shadow_par, win_par, unused_w;

    assign xfer    = DIN_VLD && din_rdy_q;
    assign win_nxt = {win_q[PRE_W-2:0], DIN};
    assign unused_w = ^{win_par, win_q[PRE_W-1]};

    clb_cfg_shreg #(.W(PRE_W)) u_win (
        .clk_i (K),
        .rst_i (RST),
        .clr_i (clr),
        .en_i  (win_en),
        .d_i   (DIN),
        .q_o   (win_q),
        .par_o (win_par)
    );

    clb_cfg_shreg #(.W(CFG_W)) u_shadow (
        .clk_i (K),
        .rst_i (RST),
        .clr_i (clr),
        .en_i  (sh_en),
        .d_i   (DIN),
        .q_o   (shadow_q),
        .par_o (shadow_par)
    );

    // next-state logic; the commit registers load while entering COMMIT so CFG and CFG_WE align
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sync_cnt_d = sync_cnt_q;
        cfg_d      = cfg_q;
        cfg_we_d   = 1'b0;
        done_d     = done_q;
        err_d      = err_q;
        clr        = 1'b0;
        win_en     = 1'b0;
        sh_en      = 1'b0;
        case (state_q)
            IDLE: if (START) begin
                state_d    = SYNC;
                done_d     = 1'b0;
                err_d      = 1'b0;
                clr        = 1'b1;
                bit_cnt_d  = '0;
                sync_cnt_d = '0;
            end
            SYNC: if (xfer) begin
                win_en     = 1'b1;
                sync_cnt_d = (sync_cnt_q == SCW'(SYNC_MAX)) ? sync_cnt_q : sync_cnt_q + SCW'(1);
                if (win_nxt == PREAMBLE) begin
                    state_d   = LOAD;
                    bit_cnt_d = '0;
                end else if (sync_cnt_q >= SCW'(SYNC_MAX - 1)) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end
            end
            LOAD: if (xfer) begin
                sh_en     = 1'b1;
                bit_cnt_d = bit_cnt_q + BCW'(1);
                state_d   = (bit_cnt_q == BCW'(CFG_W - 1)) ? PARITY : LOAD;
            end
            PARITY: if (xfer) begin
                if (shadow_par ^ DIN) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d  = COMMIT;
                    cfg_d    = shadow_q;
                    cfg_we_d = 1'b1;
                    done_d   = 1'b1;
                end
            end
            COMMIT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        din_rdy_d = (state_d == SYNC) || (state_d == LOAD) || (state_d == PARITY);
    end

    // state and output registers with synchronous reset
    always_ff @(posedge K) begin
        if (RST) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            sync_cnt_q <= '0;
            cfg_q      <= '0;
            cfg_we_q   <= 1'b0;
            din_rdy_q  <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            sync_cnt_q <= sync_cnt_d;
            cfg_q      <= cfg_d;
            cfg_we_q   <= cfg_we_d;
            din_rdy_q  <= din_rdy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign DIN_RDY = din_rdy_q;
    assign CFG     = cfg_q;
    assign CFG_WE  = cfg_we_q;
    assign BUSY    = (state_q != IDLE);
    assign DONE    = done_q;
    assign ERR     = err_q;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// tb_clb_cfg_loader: directed scoreboard bench for the clb1 configuration loader
module tb_clb_cfg_loader;

    logic        K = 1'b0;
    logic        RST = 1'b1;
    logic        START = 1'b0;
    logic        DIN = 1'b0;
    logic        DIN_VLD = 1'b0;
    logic        DIN_RDY;
    logic [33:0] CFG;
    logic        CFG_WE;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    int checks = 0;
    int failures = 0;
    logic [33:0] exp_q[$];

    localparam logic [33:0] V1 = 34'h2_AAAA_5555;
    localparam logic [33:0] V2 = 34'h0_0000_FFFF;
    localparam logic [33:0] V3 = 34'h1_1234_ABCD;

    clb_cfg_loader dut (
        .K       (K),
        .RST     (RST),
        .START   (START),
        .DIN     (DIN),
        .DIN_VLD (DIN_VLD),
        .DIN_RDY (DIN_RDY),
        .CFG     (CFG),
        .CFG_WE  (CFG_WE),
        .BUSY    (BUSY),
        .DONE    (DONE),
        .ERR     (ERR)
    );

    always #5 K = ~K;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // scoreboard: every CFG_WE pulse must match the oldest expected commit
    always @(negedge K) begin
        if (CFG_WE === 1'b1) begin
            if (exp_q.size() == 0) check("we_unexpected", 64'(CFG_WE), 64'd0);
            else check("cfg_commit", 64'(CFG), 64'(exp_q.pop_front()));
        end
    end

    task automatic send_bit(input logic b, input int gap);
        int n = 0;
        if (gap > 0) begin
            repeat ($urandom_range(0, gap)) begin
                DIN = 1'($urandom);
                DIN_VLD = 1'b0;
                @(negedge K);
            end
        end
        while (DIN_RDY !== 1'b1 && n < 200) begin
            @(negedge K);
            n++;
        end
        if (n >= 200) check("rdy_timeout", 64'(DIN_RDY), 64'd1);
        DIN = b;
        DIN_VLD = 1'b1;
        @(negedge K);
        DIN_VLD = 1'b0;
    endtask

    task automatic send_word(input logic [63:0] v, input int n, input int gap);
        for (int i = n - 1; i >= 0; i--) send_bit(v[i], gap);
    endtask

    task automatic start_load();
        START = 1'b1;
        @(negedge K);
        START = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timeout");
    end

    initial begin
        repeat (3) @(negedge K);
        RST = 1'b0;
        check("rst_cfg", 64'(CFG), 64'd0);
        check("rst_flags", 64'({CFG_WE, DIN_RDY, BUSY, DONE, ERR}), 64'd0);

        // START together with RST: reset wins
        RST = 1'b1;
        START = 1'b1;
        @(negedge K);
        RST = 1'b0;
        START = 1'b0;
        check("rst_start_busy", 64'({BUSY, DIN_RDY}), 64'd0);

        // 1: nominal load
        exp_q.push_back(V1);
        start_load();
        check("s1_rdy", 64'({BUSY, DIN_RDY}), 64'b11);
        send_word(64'hA5, 8, 0);
        send_word(64'(V1), 34, 0);
        send_bit(^V1, 0);
        check("s1_we", 64'(CFG_WE), 64'd1);
        check("s1_cfg", 64'(CFG), 64'(V1));
        check("s1_mode", 64'(CFG[clb_cfg_pkg::MODE_LSB +: 2]), 64'd2);
        @(negedge K);
        check("s1_we_off", 64'(CFG_WE), 64'd0);
        check("s1_flags", 64'({BUSY, DONE, ERR}), 64'b010);

        // 2: parity error leaves CFG alone
        start_load();
        check("s2_done_clr", 64'(DONE), 64'd0);
        send_word(64'hA5, 8, 0);
        send_word(64'(V1), 34, 0);
        send_bit(~^V1, 0);
        check("s2_flags", 64'({CFG_WE, BUSY, DONE, ERR}), 64'b0001);
        check("s2_cfg", 64'(CFG), 64'(V1));

        // 3: sync timeout after 64 zeros
        start_load();
        check("s3_err_clr", 64'(ERR), 64'd0);
        send_word(64'd0, 63, 0);
        check("s3_pre_to", 64'({BUSY, ERR}), 64'b10);
        send_bit(1'b0, 0);
        check("s3_to", 64'({DIN_RDY, BUSY, ERR}), 64'b001);
        check("s3_cfg", 64'(CFG), 64'(V1));

        // 4: junk bits and random stalls
        exp_q.push_back(V1);
        start_load();
        send_word(64'b10110, 5, 0);
        send_word(64'hA5, 8, 3);
        send_word(64'(V1), 34, 3);
        send_bit(^V1, 3);
        check("s4_cfg", 64'(CFG), 64'(V1));
        check("s4_flags", 64'({CFG_WE, DONE, ERR}), 64'b110);
        @(negedge K);

        // 5: reset mid-LOAD, then a clean load
        start_load();
        send_word(64'hA5, 8, 0);
        send_word(64'h3_FFFF_FFFF >> 14, 20, 0);
        RST = 1'b1;
        @(negedge K);
        RST = 1'b0;
        check("s5_rst_cfg", 64'(CFG), 64'd0);
        check("s5_rst_flags", 64'({CFG_WE, DIN_RDY, BUSY, DONE, ERR}), 64'd0);
        exp_q.push_back(V2);
        start_load();
        send_word(64'hA5, 8, 0);
        send_word(64'(V2), 34, 0);
        send_bit(1'b0, 0);
        check("s5_cfg", 64'(CFG), 64'(V2));
        check("s5_flags", 64'({CFG_WE, DONE, ERR}), 64'b110);

        // 6: START during LOAD is ignored; back-to-back after COMMIT
        exp_q.push_back(V3);
        @(negedge K);
        start_load();
        send_word(64'hA5, 8, 0);
        send_word(64'(V3) >> 24, 10, 0);
        start_load();
        check("s6_busy", 64'({BUSY, DIN_RDY}), 64'b11);
        check("s6_cfg_hold", 64'(CFG), 64'(V2));
        send_word(64'(V3), 24, 0);
        send_bit(^V3, 0);
        check("s6_cfg", 64'(CFG), 64'(V3));
        check("s6_flags", 64'({CFG_WE, DONE, ERR}), 64'b110);

        repeat (3) @(negedge K);
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/clb_cfg_loader.md
Name: clb_cfg_loader

Overview:
Serial configuration loader for the clb1 configurable logic block.
- Accepts a framed serial bitstream (preamble, payload, parity) over a valid/ready handshake.
- Assembles the payload in a shadow register, checks parity, then commits it atomically to the CLB configuration bus: two 16-bit LUT masks (X, Y) plus 2 output-mode bits.
- Sits between the fabric configuration port and each clb1 instance.

Parameters:
CFG_W, 34, payload width: [33:32] output-mode bits, [31:16] Y LUT, [15:0] X LUT
PRE_W, 8, preamble width
PREAMBLE, 8'hA5, sync word expected before payload
SYNC_MAX, 64, maximum bits accepted in SYNC before timeout error

Ports:
K  input  1  clock, rising edge (same clock name as clb1)
RST  input  1  synchronous active-high reset
START  input  1  one-cycle request to begin a load
DIN  input  1  serial config bit, MSB first
DIN_VLD  input  1  DIN holds a valid bit this cycle
DIN_RDY  output  1  loader accepts DIN this cycle; a bit transfers when DIN_VLD && DIN_RDY
CFG  output  CFG_W  committed configuration to clb1
CFG_WE  output  1  one-cycle pulse when CFG updates
BUSY  output  1  high in any state other than IDLE
DONE  output  1  sticky success flag; cleared by START or RST
ERR  output  1  sticky error flag (timeout or parity); cleared by START or RST

Behaviour:
Reset and handshake
- Reset (RST high at a K edge): state=IDLE; CFG=0, CFG_WE=0, DIN_RDY=0, BUSY=0, DONE=0, ERR=0; shadow register and counters cleared.
- Reset mid-load aborts the load. CFG is cleared to 0 and no CFG_WE pulse is issued.
- Only transfers (DIN_VLD && DIN_RDY) advance the shift logic. DIN_VLD low stalls with no counter change.
- DIN_RDY is registered. It is 1 in SYNC, LOAD and PARITY, and 0 in IDLE and COMMIT.

States
- IDLE: START moves to SYNC. DONE, ERR, the preamble window and bit counters are cleared on the same edge.
- SYNC: each transfer shifts DIN into an 8-bit window. The window starts at 0, and the comparison uses the updated window value.
  - Window == PREAMBLE: go to LOAD with bit count 0.
  - Otherwise, on the SYNC_MAXth transfer without a match: ERR=1, go to IDLE.
  - A match on the SYNC_MAXth transfer is success; it takes precedence over timeout.
- LOAD: each transfer is shifted into the shadow register from the LSB, so the first bit lands at CFG_W-1 after CFG_W bits. After exactly CFG_W transfers, go to PARITY.
- PARITY: one transfer carries the even-parity bit (XOR of all CFG_W payload bits XOR DIN must be 0).
  - Match: go to COMMIT.
  - Mismatch: ERR=1, go to IDLE with CFG unchanged.
- COMMIT (one cycle): CFG<=shadow, CFG_WE=1 for this cycle only, DONE=1, then IDLE. CFG_WE rises on the first K edge after the accepted parity bit, so latency is 1 cycle.

Boundary conditions
- START outside IDLE is ignored.
- START on the same edge as RST: RST wins.
- Back-to-back loads: START on the cycle after COMMIT is legal. The previous CFG is held until the new COMMIT.
- CFG changes only on a COMMIT edge or on reset. A failed or aborted load never alters CFG.
- Bit counter width is clog2(CFG_W+1). The SYNC counter saturates; it never wraps.

Decomposition:
- Shared package clb_cfg_pkg:
  - state enum {IDLE, SYNC, LOAD, PARITY, COMMIT}
  - CFG_W and PREAMBLE defaults
  - field offsets: X_LUT_LSB=0, Y_LUT_LSB=16, MODE_LSB=32
- One sub-module, clb_cfg_shreg: parameterised shift register with enable, synchronous clear and a running-parity output. It is instantiated for the preamble window and for the payload shadow.

Test Plan:
1. Nominal load: START, stream A5 then 34'h2_AAAA_5555 MSB first, parity bit 1 -> CFG_WE one cycle after the parity bit, CFG=34'h2_AAAA_5555, DONE=1, ERR=0, BUSY=0.
2. Parity error: same frame with parity bit 0 -> ERR=1, DONE=0, no CFG_WE, CFG still holds the value from scenario 1.
3. Sync timeout: START, 64 bits all zero -> ERR=1 after the 64th transfer, return to IDLE, DIN_RDY=0.
4. Stalls and junk: insert random DIN_VLD=0 gaps and 5 junk bits (10110) before A5 in scenario 1's frame -> identical CFG result; no counter advance during gaps.
5. Reset mid-LOAD: assert RST after 20 payload bits -> all outputs 0 next cycle; a following clean load of 34'h0_0000_FFFF with parity 0 commits correctly.
6. START ignored while BUSY: pulse START during LOAD -> no restart; frame completes and commits normally.
